// File: rtl/alu_logic_pkg.sv
// Shared types and defaults for the sequential bitwise logic unit.
// Op and FSM state encodings are 2 bits wide.
package alu_logic_pkg;

  localparam int WIDTH_DEF = 20;
  localparam int SLICE_DEF = 4;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_logic_seq_if.sv
// Request/response channels of the logic unit; master drives operands, slave returns results.
// Both channels use valid/ready handshakes; a transfer happens when both are high at an edge.
interface alu_logic_seq_if
  import alu_logic_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero
  );
endinterface

// File: rtl/logic_slice.sv
// Combinational SLICE-bit bitwise evaluator (AND/OR/XOR/NAND).
// Latency: none; no flow control.
module logic_slice
  import alu_logic_pkg::*;
#(
  parameter int SLICE = SLICE_DEF
) (
  input  op_e              op,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic [SLICE-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_logic_seq.sv
// Sequential bitwise logic unit; latency NSLICE cycles from accept edge to rsp_valid.
// Backpressure: one op in flight, req_ready low until the response handshake completes.
module alu_logic_seq
  import alu_logic_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic           clk,
  input  logic           rst,
  alu_logic_seq_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  state_e           state;
  state_e           state_nxt;
  op_e              op_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_zero_q;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] y_sl;
  logic             req_ready_c;
  logic             rsp_valid_c;
  logic             accept;
  logic             last;

  // Single evaluator shared across all slices, selected by the counter
  assign a_sl = a_q[cnt*SLICE +: SLICE];
  assign b_sl = b_q[cnt*SLICE +: SLICE];
  assign last = (cnt == LAST_CNT);

  logic_slice #(.SLICE(SLICE)) u_slice (
    .op (op_q),
    .a  (a_sl),
    .b  (b_sl),
    .y  (y_sl)
  );

  always_comb begin
    acc_nxt = acc;
    acc_nxt[cnt*SLICE +: SLICE] = y_sl;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake outputs are masked during reset so nothing transfers while rst is high
  always_comb begin
    state_nxt   = state;
    req_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    accept      = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready_c = !rst;
        if (bus.req_valid && !rst) begin
          accept    = 1'b1;
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        rsp_valid_c = !rst;
        if (bus.rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= OP_AND;
      cnt        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc        <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= op_e'(bus.req_op);
        a_q  <= bus.req_a;
        b_q  <= bus.req_b;
        cnt  <= '0;
        acc  <= '0;
      end else if (state == S_BUSY) begin
        acc <= acc_nxt;
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) begin
          rsp_data_q <= acc_nxt;
          rsp_zero_q <= (acc_nxt == '0);
        end
      end
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;

endmodule
